flit_injector: RTL and testbench

//  Per-router traffic source feeding the router's injection port. Queues traffic entries loaded by the top-level sequencer
//  and splits each into head/body/tail flits. Emits at most one flit per Phase0 step, gated by the router's can_inject VC mask.

---
 rtl/flit_injector_pkg.sv | 74 +++++++
 rtl/flit_injector_traffic_fifo.sv | 49 ++++
 rtl/flit_injector.sv | 140 ++++++++++++++
 tb/tb_flit_injector.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/flit_injector_pkg.sv
// Shared widths, sequencer op codes, entry/flit layouts and helpers for flit_injector.
// Optional statistics outputs are enabled by defining INJECT_STATS_EN.
package flit_injector_pkg;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CYC_W  = 16;
  localparam int unsigned DST_W  = 4;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned VC_W   = 2;
  localparam int unsigned ID_W   = 8;
  localparam int unsigned NUM_VC = 1 << VC_W;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned FLIT_W = 32;
  localparam int unsigned STAT_W = 32;

  // Traffic entry packed LSB-first as cycle, dst, len, vc
  localparam int unsigned ENTRY_CYC_LSB = 0;
  localparam int unsigned ENTRY_DST_LSB = ENTRY_CYC_LSB + CYC_W;
  localparam int unsigned ENTRY_LEN_LSB = ENTRY_DST_LSB + DST_W;
  localparam int unsigned ENTRY_VC_LSB  = ENTRY_LEN_LSB + LEN_W;
  localparam int unsigned ENTRY_W       = ENTRY_VC_LSB + VC_W;

  // Flit packed LSB-first as seq, pkt_id, dst, vc, tail, head, valid
  localparam int unsigned FLIT_SEQ_LSB = 0;
  localparam int unsigned FLIT_ID_LSB  = FLIT_SEQ_LSB + LEN_W;
  localparam int unsigned FLIT_DST_LSB = FLIT_ID_LSB + ID_W;
  localparam int unsigned FLIT_VC_LSB  = FLIT_DST_LSB + DST_W;
  localparam int unsigned FLIT_TAIL    = FLIT_VC_LSB + VC_W;
  localparam int unsigned FLIT_HEAD    = FLIT_TAIL + 1;
  localparam int unsigned FLIT_VALID   = FLIT_HEAD + 1;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 3'd0,
    OP_INIT   = 3'd1,
    OP_LOAD   = 3'd2,
    OP_PHASE0 = 3'd3,
    OP_PHASE1 = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  typedef struct packed {
    logic [VC_W-1:0]  vc;
    logic [LEN_W-1:0] len;
    logic [DST_W-1:0] dst;
    logic [CYC_W-1:0] cycle;
  } entry_t;

  typedef struct packed {
    logic             valid;
    logic             head;
    logic             tail;
    logic [VC_W-1:0]  vc;
    logic [DST_W-1:0] dst;
    logic [ID_W-1:0]  pkt_id;
    logic [LEN_W-1:0] seq;
  } flit_t;

  function automatic entry_t unpack_entry(input logic [DATA_W-1:0] d);
    return entry_t'(d[ENTRY_W-1:0]);
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : STAT_W'(v + 1'b1);
  endfunction

endpackage

// File: rtl/flit_injector_traffic_fifo.sv
// Circular queue of traffic entries; full/empty are registered alongside the count.
module flit_injector_traffic_fifo
  import flit_injector_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  entry_t           wr_data,
  output entry_t           rd_data_c,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  entry_t             mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic               push_ok_c;
  logic               pop_ok_c;
  logic [CNT_W-1:0]   count_next_c;

  assign push_ok_c    = push && !full;
  assign pop_ok_c     = pop && !empty;
  assign count_next_c = CNT_W'(count + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c));
  assign rd_data_c    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok_c) wr_ptr <= ADDR_W'(wr_ptr + 1'b1);
      if (pop_ok_c)  rd_ptr <= ADDR_W'(rd_ptr + 1'b1);
      count <= count_next_c;
      full  <= (count_next_c == CNT_W'(DEPTH));
      empty <= (count_next_c == '0);
    end
  end

endmodule

// File: rtl/flit_injector.sv
// Per-router traffic source: queues entries and emits head/body/tail flits on Phase0 steps.
// Define INJECT_STATS_EN to add pkts_sent/flits_sent/stall_cycles counters.
module flit_injector
  import flit_injector_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] data,
  input  logic [CYC_W-1:0]  in_cycle,
  input  logic [NUM_VC-1:0] can_inject,
  output logic [FLIT_W-1:0] flit,
  output logic              done,
`ifdef INJECT_STATS_EN
  output logic [STAT_W-1:0] pkts_sent,
  output logic [STAT_W-1:0] flits_sent,
  output logic [STAT_W-1:0] stall_cycles,
`endif
  output logic              overflow
);

  state_e            state;
  logic [LEN_W-1:0]  seq;
  logic [ID_W-1:0]   pkt_id;

  entry_t            head_c;
  logic              q_full;
  logic              q_empty;
  logic [CNT_W-1:0]  q_count;

  logic              clr_c;
  logic              push_c;
  logic              drop_c;
  logic              cycle_ok_c;
  logic              eligible_c;
  logic              vc_ready_c;
  logic              phase0_c;
  logic              emit_c;
  logic              tail_c;
  logic              stall_c;
  logic [LEN_W-1:0]  last_seq_c;
  logic [CNT_W-1:0]  count_next_c;
  flit_t             flit_c;
  logic              unused_data_c;

  assign clr_c      = rst || (op == OP_INIT);
  assign push_c     = (op == OP_LOAD);
  assign drop_c     = push_c && q_full;
  assign phase0_c   = (op == OP_PHASE0);
  assign cycle_ok_c = (head_c.cycle <= in_cycle);
  // Once a packet has started the cycle gate no longer applies
  assign eligible_c = !q_empty && ((state == ST_SEND) || cycle_ok_c);
  assign vc_ready_c = can_inject[head_c.vc];
  assign emit_c     = phase0_c && eligible_c && vc_ready_c;
  assign stall_c    = phase0_c && eligible_c && !vc_ready_c;
  // A zero-length entry is sent as a single head+tail flit
  assign last_seq_c = (head_c.len == '0) ? '0 : LEN_W'(head_c.len - 1'b1);
  assign tail_c     = emit_c && (seq == last_seq_c);
  assign count_next_c = CNT_W'(q_count + CNT_W'(push_c && !q_full) - CNT_W'(tail_c));
  assign unused_data_c = ^data[DATA_W-1:ENTRY_W];

  always_comb begin
    flit_c        = '0;
    flit_c.valid  = 1'b1;
    flit_c.head   = (seq == '0);
    flit_c.tail   = tail_c;
    flit_c.vc     = head_c.vc;
    flit_c.dst    = head_c.dst;
    flit_c.pkt_id = pkt_id;
    flit_c.seq    = seq;
  end

  flit_injector_traffic_fifo u_fifo (
    .clk       (clk),
    .rst       (clr_c),
    .push      (push_c),
    .pop       (tail_c),
    .wr_data   (unpack_entry(data)),
    .rd_data_c (head_c),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Injection FSM with registered flit/done/overflow
  always_ff @(posedge clk) begin
    if (clr_c) begin
      state    <= ST_IDLE;
      seq      <= '0;
      pkt_id   <= '0;
      flit     <= '0;
      done     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      flit <= '0;
      // The FSM is idle whenever the queue is empty, so done tracks the next count
      done <= (count_next_c == '0);
      if (drop_c) overflow <= 1'b1;

      if (tail_c) begin
        state <= (count_next_c != '0) ? ST_WAIT : ST_IDLE;
      end else if (emit_c) begin
        state <= ST_SEND;
      end else begin
        case (state)
          ST_IDLE: if (!q_empty) state <= ST_WAIT;
          ST_WAIT: if (!q_empty && cycle_ok_c) state <= ST_SEND;
          ST_SEND: state <= ST_SEND;
          default: state <= ST_IDLE;
        endcase
      end

      if (emit_c) begin
        flit <= FLIT_W'(flit_c);
        if (tail_c) begin
          seq    <= '0;
          pkt_id <= ID_W'(pkt_id + 1'b1);
        end else begin
          seq <= LEN_W'(seq + 1'b1);
        end
      end
    end
  end

`ifdef INJECT_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clk) begin
    if (clr_c) begin
      pkts_sent    <= '0;
      flits_sent   <= '0;
      stall_cycles <= '0;
    end else begin
      if (tail_c)  pkts_sent    <= sat_inc(pkts_sent);
      if (emit_c)  flits_sent   <= sat_inc(flits_sent);
      if (stall_c) stall_cycles <= sat_inc(stall_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_flit_injector.sv
// Directed bench for flit_injector with a queue-based reference model and per-cycle compare.
module tb_flit_injector;
  import flit_injector_pkg::*;

  typedef struct {
    int cyc;
    int dst;
    int len;
    int vc;
  } ment_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] data;
  logic [CYC_W-1:0]  in_cycle;
  logic [NUM_VC-1:0] can_inject;
  logic [FLIT_W-1:0] flit;
  logic              done;
  logic              overflow;
`ifdef INJECT_STATS_EN
  logic [STAT_W-1:0] pkts_sent;
  logic [STAT_W-1:0] flits_sent;
  logic [STAT_W-1:0] stall_cycles;
`endif

  flit_injector dut (
    .clk          (clk),
    .rst          (rst),
    .op           (op),
    .data         (data),
    .in_cycle     (in_cycle),
    .can_inject   (can_inject),
    .flit         (flit),
    .done         (done),
`ifdef INJECT_STATS_EN
    .pkts_sent    (pkts_sent),
    .flits_sent   (flits_sent),
    .stall_cycles (stall_cycles),
`endif
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  ment_t mq[$];
  int    m_id, m_seq, m_pkts, m_flits, m_stalls;
  bit    m_ovf;

  logic [31:0] exp_flit;
  bit          exp_done, exp_ovf;
  int          exp_pkts, exp_flits, exp_stalls;
  bit          chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_entry(input int cyc, input int dst, input int len, input int vc);
    return 32'(cyc) + 32'(dst) * 32'h1_0000 + 32'(len) * 32'h10_0000 + 32'(vc) * 32'h100_0000;
  endfunction

  // Flit fields in order seq, pkt_id, dst, vc, tail, head, valid from bit 0 upward
  function automatic logic [31:0] mk_flit(input bit hd, input bit tl, input int vc, input int dst,
                                          input int id, input int sq);
    int sh;
    logic [31:0] f;
    f  = 32'(sq);
    sh = LEN_W;               f = f | (32'(id)  << sh);
    sh = sh + ID_W;           f = f | (32'(dst) << sh);
    sh = sh + DST_W;          f = f | (32'(vc)  << sh);
    sh = sh + VC_W;           f = f | (32'(tl)  << sh);
    sh = sh + 1;              f = f | (32'(hd)  << sh);
    sh = sh + 1;              f = f | (32'd1    << sh);
    return f;
  endfunction

  // One clock: drive inputs, advance the model, publish expectations after the edge
  task automatic step(input bit r, input op_e o, input logic [31:0] d, input int cyc,
                      input logic [NUM_VC-1:0] m);
    ment_t h;
    ment_t e;
    int L;
    logic [31:0] nf;
    nf = '0;
    @(negedge clk);
    rst = r; op = o; data = d; in_cycle = CYC_W'(cyc); can_inject = m;
    if (r || o == OP_INIT) begin
      mq.delete();
      m_id = 0; m_seq = 0; m_ovf = 0; m_pkts = 0; m_flits = 0; m_stalls = 0;
    end else if (o == OP_LOAD) begin
      e.cyc = int'(d & 32'hFFFF);
      e.dst = int'((d >> 16) & 32'hF);
      e.len = int'((d >> 20) & 32'hF);
      e.vc  = int'((d >> 24) & 32'h3);
      if (mq.size() < DEPTH) mq.push_back(e);
      else m_ovf = 1;
    end else if (o == OP_PHASE0 && mq.size() > 0) begin
      h = mq[0];
      L = (h.len == 0) ? 1 : h.len;
      if (m_seq > 0 || h.cyc <= cyc) begin
        if (m[h.vc]) begin
          nf = mk_flit(m_seq == 0, m_seq == L - 1, h.vc, h.dst, m_id, m_seq);
          m_flits++;
          if (m_seq == L - 1) begin
            void'(mq.pop_front());
            m_id = (m_id + 1) % 256;
            m_seq = 0;
            m_pkts++;
          end else begin
            m_seq++;
          end
        end else begin
          m_stalls++;
        end
      end
    end
    @(posedge clk);
    #1;
    exp_flit   = nf;
    exp_done   = (mq.size() == 0);
    exp_ovf    = m_ovf;
    exp_pkts   = m_pkts;
    exp_flits  = m_flits;
    exp_stalls = m_stalls;
    chk_en     = 1'b1;
  endtask

  task automatic tick(input int cyc, input logic [NUM_VC-1:0] m);
    step(0, OP_PHASE0, '0, cyc, m);
    step(0, OP_PHASE1, '0, cyc, m);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("flit", flit, exp_flit);
      check("done", 32'(done), 32'(exp_done));
      check("overflow", 32'(overflow), 32'(exp_ovf));
`ifdef INJECT_STATS_EN
      check("pkts_sent", pkts_sent, 32'(exp_pkts));
      check("flits_sent", flits_sent, 32'(exp_flits));
      check("stall_cycles", stall_cycles, 32'(exp_stalls));
`endif
    end
  end

  initial begin
    rst = 1'b1; op = OP_NOP; data = '0; in_cycle = '0; can_inject = '0;

    // reset
    step(1, OP_NOP, '0, 0, 4'hF);
    step(1, OP_NOP, '0, 0, 4'hF);
    check("rst_flit", flit, 32'h0);
    check("rst_done", 32'(done), 32'd1);
    check("rst_ovf", 32'(overflow), 32'd0);
    step(0, OP_PHASE0, '0, 0, 4'hF);
    check("rst_phase0_flit", flit, 32'h0);

    // single packet waits for its cycle
    step(0, OP_LOAD, mk_entry(3, 5, 3, 1), 0, 4'hF);
    step(0, OP_NOP, '0, 0, 4'hF);
    for (int c = 0; c < 3; c++) tick(c, 4'hF);
    step(0, OP_PHASE0, '0, 3, 4'hF);
    check("single_seq0", flit, 32'h0019_5000);
    step(0, OP_PHASE1, '0, 3, 4'hF);
    step(0, OP_PHASE0, '0, 4, 4'hF);
    check("single_seq1", flit, 32'h0011_5001);
    step(0, OP_PHASE1, '0, 4, 4'hF);
    step(0, OP_PHASE0, '0, 5, 4'hF);
    check("single_seq2", flit, 32'h0015_5002);
    step(0, OP_PHASE1, '0, 5, 4'hF);
    check("single_done", 32'(done), 32'd1);

    // stall on vc 2
    step(0, OP_LOAD, mk_entry(6, 9, 2, 2), 6, 4'hF);
    step(0, OP_NOP, '0, 6, 4'hF);
    for (int i = 0; i < 3; i++) tick(6, 4'b1011);
`ifdef INJECT_STATS_EN
    check("stall_count", stall_cycles, 32'd3);
`endif
    step(0, OP_PHASE0, '0, 6, 4'hF);
    check("stall_release_head", flit, 32'h001A_9010);
    step(0, OP_PHASE1, '0, 6, 4'hF);
    tick(7, 4'hF);

    // overflow and drain
    step(0, OP_INIT, '0, 8, 4'hF);
    for (int i = 0; i < DEPTH + 1; i++) step(0, OP_LOAD, mk_entry(8, i % 16, 1, i % 4), 8, 4'hF);
    check("ovf_set", 32'(overflow), 32'd1);
    for (int k = 0; k < DEPTH; k++) begin
      step(0, OP_PHASE0, '0, 8, 4'hF);
      check("drain_pkt_id", (flit >> 4) & 32'hFF, 32'(k));
      step(0, OP_PHASE1, '0, 8, 4'hF);
    end
    tick(8, 4'hF);
    check("drain_done", 32'(done), 32'd1);

    // zero length, late entry
    step(0, OP_LOAD, mk_entry(1, 3, 0, 0), 7, 4'hF);
    step(0, OP_PHASE0, '0, 7, 4'hF);
    check("len0_late", flit, 32'h001C_3100);
    step(0, OP_PHASE1, '0, 7, 4'hF);

    // reset in the middle of a packet
    step(0, OP_LOAD, mk_entry(7, 2, 4, 3), 7, 4'hF);
    step(0, OP_NOP, '0, 7, 4'hF);
    tick(7, 4'hF);
    tick(8, 4'hF);
    step(1, OP_NOP, '0, 8, 4'hF);
    check("midrst_flit", flit, 32'h0);
    check("midrst_done", 32'(done), 32'd1);
    step(0, OP_LOAD, mk_entry(9, 4, 2, 0), 9, 4'hF);
    step(0, OP_PHASE0, '0, 9, 4'hF);
    check("midrst_restart", flit, 32'h0018_4000);
    step(0, OP_PHASE1, '0, 9, 4'hF);
    tick(10, 4'hF);
    step(0, OP_NOP, '0, 10, 4'hF);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
